// File: rtl/exe_stage.sv
// Execute stage of the 5-stage in-order LoongArch32 pipeline.
// Latches one instruction from decode and computes its result:
//   - a 12-op ALU,
//   - a single-cycle 33x33 signed multiplier,
//   - an iterative radix-2 restoring divider that stalls the stage.
// The stage then issues the data-SRAM request, forwards the result bus to
// MEM, and returns a forwarding/hazard bundle to decode.
// Ports:
//   clk, resetn        clock; synchronous active-low reset
//   ds_to_es_valid/bus decode handshake in (155-bit bus)
//   es_allowin         stage can accept a new instruction this cycle
//   ms_allowin         memory stage can accept
//   es_to_ms_valid/bus result handshake out (71-bit bus)
//   es_rf_collect      {rfm&valid, we&valid, waddr, result} back to decode
//   data_sram_*        data memory request (en, byte we, addr, wdata)
module exe_stage #(
    parameter int unsigned DS_BUS_W = 155,
    parameter int unsigned ES_BUS_W = 71,
    parameter int unsigned DIV_ITER = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ds_to_es_valid,
    output logic                es_allowin,
    input  logic [DS_BUS_W-1:0] ds_to_es_bus,
    input  logic                ms_allowin,
    output logic                es_to_ms_valid,
    output logic [ES_BUS_W-1:0] es_to_ms_bus,
    output logic [38:0]         es_rf_collect,
    output logic                data_sram_en,
    output logic [3:0]          data_sram_we,
    output logic [31:0]         data_sram_addr,
    output logic [31:0]         data_sram_wdata
);

    localparam int unsigned CNT_W = $clog2(DIV_ITER + 1);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    logic                es_valid_q;
    logic [DS_BUS_W-1:0] ds_bus_q;
    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         quo_q, quo_d;
    logic [31:0]         rem_q, rem_d;

    // Latched instruction fields
    logic [18:0] op19;
    logic        res_from_mem, mem_we, rf_we;
    logic [31:0] src1, src2, rkd_value, pc;
    logic [4:0]  rf_waddr;

    assign op19         = ds_bus_q[154:136];
    assign res_from_mem = ds_bus_q[135];
    assign src1         = ds_bus_q[134:103];
    assign src2         = ds_bus_q[102:71];
    assign mem_we       = ds_bus_q[70];
    assign rf_we        = ds_bus_q[69];
    assign rf_waddr     = ds_bus_q[68:64];
    assign rkd_value    = ds_bus_q[63:32];
    assign pc           = ds_bus_q[31:0];

    logic        mul_w, mulh_w, mulh_wu, div_w, mod_w, div_wu, mod_wu;
    logic [11:0] alu_op;

    assign {mul_w, mulh_w, mulh_wu, div_w, mod_w, div_wu, mod_wu} = op19[18:12];
    assign alu_op = op19[11:0];

    // ALU: one-hot op select, all-zero op yields zero
    logic [31:0] add_res, sub_res, sra_res, alu_res;

    assign add_res = src1 + src2;
    assign sub_res = src1 - src2;
    assign sra_res = $signed(src1) >>> src2[4:0];

    always_comb begin
        alu_res = ({32{alu_op[0]}}  & add_res)
                | ({32{alu_op[1]}}  & sub_res)
                | ({32{alu_op[2]}}  & {31'd0, $signed(src1) < $signed(src2)})
                | ({32{alu_op[3]}}  & {31'd0, src1 < src2})
                | ({32{alu_op[4]}}  & (src1 & src2))
                | ({32{alu_op[5]}}  & ~(src1 | src2))
                | ({32{alu_op[6]}}  & (src1 | src2))
                | ({32{alu_op[7]}}  & (src1 ^ src2))
                | ({32{alu_op[8]}}  & (src1 << src2[4:0]))
                | ({32{alu_op[9]}}  & (src1 >> src2[4:0]))
                | ({32{alu_op[10]}} & sra_res)
                | ({32{alu_op[11]}} & src2);
    end

    // Multiplier: one extra bit per operand so mulh_wu can zero-extend
    logic               mul_sext;
    logic        [32:0] mul_a, mul_b;
    logic signed [65:0] prod;

    assign mul_sext = ~mulh_wu;
    assign mul_a    = {mul_sext & src1[31], src1};
    assign mul_b    = {mul_sext & src2[31], src2};
    assign prod     = $signed(mul_a) * $signed(mul_b);

    // Divider operand magnitudes and sign fixup; bus is frozen while dividing
    logic        is_div, div_signed, dvd_neg, dsr_neg, div_by_zero;
    logic [31:0] dvd_mag, dsr_mag, quo_fix, rem_fix, div_res;
    logic [33:0] trial;

    assign is_div      = div_w | mod_w | div_wu | mod_wu;
    assign div_signed  = div_w | mod_w;
    assign dvd_neg     = div_signed & src1[31];
    assign dsr_neg     = div_signed & src2[31];
    assign dvd_mag     = dvd_neg ? (~src1 + 32'd1) : src1;
    assign dsr_mag     = dsr_neg ? (~src2 + 32'd1) : src2;
    assign div_by_zero = (src2 == 32'd0);

    // Shifted partial remainder minus divisor; bit 33 set means it does not fit
    assign trial = {1'b0, rem_q, quo_q[31]} - {2'b00, dsr_mag};

    assign quo_fix = div_by_zero       ? 32'hFFFF_FFFF
                   : (dvd_neg ^ dsr_neg) ? (~quo_q + 32'd1) : quo_q;
    assign rem_fix = div_by_zero ? src1
                   : dvd_neg     ? (~rem_q + 32'd1) : rem_q;
    assign div_res = (div_w | div_wu) ? quo_fix : rem_fix;

    // Handshake
    logic es_ready_go;

    assign es_ready_go    = ~is_div | (state_q == DIV_DONE);
    assign es_allowin     = ~es_valid_q | (es_ready_go & ms_allowin);
    assign es_to_ms_valid = es_valid_q & es_ready_go;

    // Divider next-state and datapath
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (es_valid_q & is_div) begin
                    state_d = DIV_BUSY;
                    cnt_d   = '0;
                    quo_d   = dvd_mag;
                    rem_d   = '0;
                end
            end
            DIV_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!trial[33]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = {rem_q[30:0], quo_q[31]};
                    quo_d = {quo_q[30:0], 1'b0};
                end
                if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (es_to_ms_valid & ms_allowin) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    // Stage and divider registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            es_valid_q <= 1'b0;
            ds_bus_q   <= '0;
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
        end else begin
            if (es_allowin) begin
                es_valid_q <= ds_to_es_valid;
            end
            if (ds_to_es_valid & es_allowin) begin
                ds_bus_q <= ds_to_es_bus;
            end
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    // Result select
    logic [31:0] es_result;

    always_comb begin
        es_result = alu_res;
        if (mul_w) begin
            es_result = prod[31:0];
        end
        if (mulh_w | mulh_wu) begin
            es_result = prod[63:32];
        end
        if (is_div) begin
            es_result = div_res;
        end
    end

    assign es_to_ms_bus  = {res_from_mem, rf_we, rf_waddr, es_result, pc};
    assign es_rf_collect = {res_from_mem & es_valid_q, rf_we & es_valid_q, rf_waddr, es_result};

    // Memory request only when MEM can take it, so a stall never repeats it
    assign data_sram_en    = es_valid_q & (res_from_mem | mem_we) & ms_allowin;
    assign data_sram_we    = {4{data_sram_en & mem_we}};
    assign data_sram_addr  = add_res;
    assign data_sram_wdata = rkd_value;

    // Product guard bits and trial bit 32 carry no information
    logic unused_bits;
    assign unused_bits = ^{prod[65:64], trial[32]};

endmodule
